// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with show-ahead read data and count-based full/empty.
// Writes when full and reads when empty are ignored; full/empty reflect registered state.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_wr;
  logic               do_rd;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised onto TXD at clk_uart tick rate.
// A write into an idle block drives the start bit 2 cycles later; writes to a full FIFO are dropped and flagged.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       clk_uart,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       TXD,
  output logic       bps_en,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       interrupt
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state, state_nxt;
  logic [UART_DATA_BITS-1:0] shift, shift_nxt;
  logic [2:0]                bit_cnt, bit_cnt_nxt;
  logic                      txd_nxt;
  logic                      bps_nxt;
  logic                      irq_nxt;
  logic                      pop;
  logic [7:0]                rd_data;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .RSTn    (RSTn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy = (state != IDLE) | ~fifo_empty;

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    txd_nxt     = TXD;
    bps_nxt     = bps_en;
    irq_nxt     = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt = UART_IDLE_LEVEL;
        bps_nxt = 1'b0;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_nxt   = rd_data;
          bit_cnt_nxt = '0;
          state_nxt   = START;
          txd_nxt     = 1'b0;
          bps_nxt     = 1'b1;
        end
      end
      START: begin
        if (clk_uart) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          txd_nxt     = shift[0];
        end
      end
      DATA: begin
        if (clk_uart) begin
          shift_nxt = {UART_IDLE_LEVEL, shift[UART_DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
            txd_nxt   = UART_IDLE_LEVEL;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            txd_nxt     = shift[1];
          end
        end
      end
      STOP: begin
        if (clk_uart) begin
          irq_nxt = 1'b1;
          // Chain straight into the next frame so the baud generator never pauses.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_nxt   = rd_data;
            bit_cnt_nxt = '0;
            state_nxt   = START;
            txd_nxt     = 1'b0;
          end else begin
            state_nxt = IDLE;
            txd_nxt   = UART_IDLE_LEVEL;
            bps_nxt   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      shift     <= 8'hFF;
      bit_cnt   <= '0;
      TXD       <= UART_IDLE_LEVEL;
      bps_en    <= 1'b0;
      interrupt <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      TXD       <= txd_nxt;
      bps_en    <= bps_nxt;
      interrupt <= irq_nxt;
      overflow  <= wr_en & fifo_full;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a bit-stream model of every accepted byte is checked against TXD, busy and interrupt each cycle.
module tb_uart_tx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       clk_uart;
  logic       wr_en;
  logic       wr_keep;
  logic [7:0] wr_data;
  logic       TXD, bps_en, busy, fifo_full, fifo_empty, overflow, interrupt;

  always #5 clk = ~clk;

  uart_tx #(
    .FIFO_DEPTH (4),
    .FIFO_AW    (2)
  ) dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .clk_uart   (clk_uart),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .TXD        (TXD),
    .bps_en     (bps_en),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .interrupt  (interrupt)
  );

  int checks;
  int errors;
  bit exp_bits[$];
  bit cap[$];
  int rd_idx;
  int irq_cnt, ovf_cnt, rise_cnt, fall_cnt;
  bit irq_due;
  bit prev_bps;
  bit stall;
  int div_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pending();
    return exp_bits.size() - rd_idx;
  endfunction

  function automatic logic [7:0] cap_byte(input int base, input int frame);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (base + frame * 10 + 1 + i < cap.size()) b[i] = cap[base + frame * 10 + 1 + i];
    end
    return b;
  endfunction

  task automatic wr(input logic [7:0] d, input bit keep);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_data = d;
    wr_keep = keep;
  endtask

  task automatic wr_stop();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_keep = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((busy || pending() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_pending(input string name, input int p, input int limit);
    int n;
    n = 0;
    while (pending() != p && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_pending_timeout"}, pending(), p);
  endtask

  initial begin
    int b0, i0, f0, r0, o0;
    logic [9:0]  exp10;
    logic [19:0] exp20;

    RSTn = 1'b0; wr_en = 1'b0; wr_keep = 1'b0; wr_data = 8'h00; clk_uart = 1'b0;
    stall = 1'b0; checks = 0; errors = 0; rd_idx = 0; irq_cnt = 0; ovf_cnt = 0;
    rise_cnt = 0; fall_cnt = 0; irq_due = 1'b0; prev_bps = 1'b0; div_cnt = 0;

    fork
      // Model: every accepted write appends one 10-bit frame to the expected stream.
      forever begin
        @(posedge clk);
        if (RSTn && wr_en && wr_keep) begin
          exp_bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) exp_bits.push_back(wr_data[i]);
          exp_bits.push_back(1'b1);
        end
      end
      // Per-cycle compare plus the baud generator, both on the falling edge.
      forever begin
        @(negedge clk);
        if (!RSTn) begin
          rd_idx   = exp_bits.size();
          irq_due  = 1'b0;
          div_cnt  = 0;
          clk_uart = 1'b0;
          prev_bps = 1'b0;
        end else begin
          chk("interrupt", interrupt, irq_due);
          irq_due = 1'b0;
          chk("busy", busy, pending() != 0);
          if (overflow) ovf_cnt++;
          if (interrupt) irq_cnt++;
          if (bps_en && !prev_bps) rise_cnt++;
          if (!bps_en && prev_bps) fall_cnt++;
          prev_bps = bps_en;
          if (!bps_en) chk("txd_idle", TXD, 1);
          else if (pending() == 0) chk("bps_en_without_data", bps_en, 0);
          else chk("txd_bit", TXD, exp_bits[rd_idx]);
          if (!bps_en) begin
            div_cnt  = 0;
            clk_uart = 1'b0;
          end else if (stall) begin
            clk_uart = 1'b0;
          end else begin
            div_cnt++;
            clk_uart = (div_cnt == DIV);
            if (div_cnt == DIV) div_cnt = 0;
          end
          if (clk_uart && pending() != 0) begin
            cap.push_back(TXD);
            if ((rd_idx % 10) == 9) irq_due = 1'b1;
            rd_idx++;
          end
        end
      end
      begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #12;
    chk("rst_txd", TXD, 1);
    chk("rst_bps_en", bps_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_interrupt", interrupt, 0);
    @(posedge clk);
    #1;
    RSTn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single byte A5 with latency pin
    b0 = cap.size(); i0 = irq_cnt; f0 = fall_cnt;
    wr(8'hA5, 1'b1);
    wr_stop();
    chk("lat1_txd", TXD, 1);
    chk("lat1_fifo_empty", fifo_empty, 0);
    @(posedge clk);
    #1;
    chk("lat2_txd", TXD, 0);
    chk("lat2_bps_en", bps_en, 1);
    wait_idle("a5", 400);
    exp10 = 10'b1101001010;
    chk("a5_bits", cap.size() - b0, 10);
    for (int i = 0; i < 10; i++) chk("a5_bit", cap[b0 + i], exp10[i]);
    chk("a5_irq", irq_cnt - i0, 1);
    chk("a5_bps_fall", fall_cnt - f0, 1);
    chk("a5_bps_en", bps_en, 0);

    // Back-to-back 00, FF
    b0 = cap.size(); i0 = irq_cnt; f0 = fall_cnt; r0 = rise_cnt;
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    wr_stop();
    wait_idle("b2b", 800);
    exp20 = 20'b1111111110_1000000000;
    chk("b2b_bits", cap.size() - b0, 20);
    for (int i = 0; i < 20; i++) chk("b2b_bit", cap[b0 + i], exp20[i]);
    chk("b2b_irq", irq_cnt - i0, 2);
    chk("b2b_bps_rise", rise_cnt - r0, 1);
    chk("b2b_bps_fall", fall_cnt - f0, 1);

    // Five writes while idle: one pop keeps the FIFO from filling
    b0 = cap.size(); i0 = irq_cnt; o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
    wr_stop();
    wait_idle("five", 2000);
    chk("five_frames", cap.size() - b0, 50);
    for (int f = 0; f < 5; f++) chk("five_byte", cap_byte(b0, f), 32'(f + 1));
    chk("five_irq", irq_cnt - i0, 5);
    chk("five_overflow", ovf_cnt - o0, 0);

    // Line stalled: sixth write dropped
    stall = 1'b1;
    b0 = cap.size(); o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
    wr(8'h06, 1'b0);
    wr_stop();
    repeat (2) @(posedge clk);
    #1;
    chk("stall_fifo_full", fifo_full, 1);
    chk("stall_overflow", ovf_cnt - o0, 1);
    chk("stall_bps_en", bps_en, 1);
    chk("stall_txd_start", TXD, 0);
    stall = 1'b0;
    wait_idle("ovf", 2000);
    chk("ovf_frames", cap.size() - b0, 50);
    for (int f = 0; f < 5; f++) chk("ovf_byte", cap_byte(b0, f), 32'(f + 1));
    chk("ovf_overflow_total", ovf_cnt - o0, 1);

    // Reset during data bit 3 of C3 with a second byte queued
    wr(8'hC3, 1'b1);
    wr(8'h77, 1'b1);
    wr_stop();
    wait_pending("rst_mid", 16, 400);
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_txd", TXD, 0);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_txd", TXD, 1);
    chk("mid_rst_bps_en", bps_en, 0);
    chk("mid_rst_fifo_empty", fifo_empty, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    RSTn = 1'b1;
    b0 = cap.size();
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_ticks", cap.size() - b0, 0);
    chk("post_rst_bps_en", bps_en, 0);
    chk("post_rst_txd", TXD, 1);

    // Tick stall during data bit 2 of 5A
    b0 = cap.size(); i0 = irq_cnt;
    wr(8'h5A, 1'b1);
    wr_stop();
    wait_pending("tstall", 7, 400);
    stall = 1'b1;
    chk("tstall_txd_begin", TXD, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("tstall_txd_hold", TXD, 0);
    chk("tstall_bps_en", bps_en, 1);
    chk("tstall_no_ticks", cap.size() - b0, 3);
    stall = 1'b0;
    wait_idle("tstall", 600);
    chk("tstall_byte", cap_byte(b0, 0), 8'h5A);
    chk("tstall_irq", irq_cnt - i0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
